// File: rtl/game_referee_pkg.sv
// Shared constants and types for the player modules and the game referee.
package game_referee_pkg;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [1:0] HEALTH_FULL = 2'b11;
    localparam logic [1:0] HEALTH_DEAD = 2'b00;

    typedef enum logic [1:0] {ST_PLAY, ST_TURN, ST_JUDGE, ST_OVER} ref_state_e;

    localparam logic [1:0] ACT_IDLE   = 2'b00;
    localparam logic [1:0] ACT_ATTACK = 2'b01;
    localparam logic [1:0] ACT_HEAVY  = 2'b10;
    localparam logic [1:0] ACT_HEAL   = 2'b11;

    localparam logic [2:0] POS_LEFT  = 3'b001;
    localparam logic [2:0] POS_MID   = 3'b010;
    localparam logic [2:0] POS_RIGHT = 3'b100;

    // A rise of more than one point can only be a 2-bit wrap after a big hit.
    function automatic logic is_dead(input logic [1:0] h, input logic [1:0] prev);
        return (h == HEALTH_DEAD) || ({1'b0, h} > ({1'b0, prev} + 3'd1));
    endfunction

endpackage

// File: rtl/game_referee_if.sv
// Turn strobe, health inputs and verdict outputs shared by the referee and its neighbours.
interface game_referee_if #(parameter int TURN_W = 6);
    logic              actionEnable;
    logic [1:0]        health1;
    logic [1:0]        health2;
    logic              isGameOver;
    logic [1:0]        winner;
    logic [TURN_W-1:0] turnCount;

    modport master (output actionEnable, health1, health2,
                    input  isGameOver, winner, turnCount);
    modport slave  (input  actionEnable, health1, health2,
                    output isGameOver, winner, turnCount);
endinterface

// File: rtl/game_referee_enable_edge_detect.sv
// Registers the turn strobe and flags its rising and falling edges.
module enable_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_level <= 1'b0;
        else       r_level <= i_level;
    end

    assign o_rise = i_level & ~r_level;
    assign o_fall = ~i_level & r_level;
endmodule

// File: rtl/game_referee.sv
// Judges knock-out, turn-limit and draw outcomes after each completed turn.
// Optional idle forfeit enabled by defining REFEREE_INACTIVITY_TIMEOUT_EN.
module game_referee
    import game_referee_pkg::*;
#(
    parameter int MAX_TURNS      = 32,
    parameter int TURN_W         = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    game_referee_if.slave io_bus
);
    localparam logic [TURN_W-1:0] TURN_MAX = TURN_W'(MAX_TURNS);

    if (TURN_W < $clog2(MAX_TURNS + 1) || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("game_referee: bad TURN_W/MAX_TURNS/TIMEOUT_CYCLES");
    end

    ref_state_e        r_state, w_state_nxt;
    logic [1:0]        r_h1, r_h2, r_prev1, r_prev2, r_win, w_dec;
    logic [TURN_W-1:0] r_turn;
    logic              r_over, w_rise, w_fall, w_dead1, w_dead2, w_idle_to;

    enable_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .i_level (io_bus.actionEnable),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

`ifdef REFEREE_INACTIVITY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] r_idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     r_idle <= '0;
        else if (io_bus.actionEnable)  r_idle <= '0;
        else if (r_state == ST_PLAY && r_idle != IDLE_W'(TIMEOUT_CYCLES))
                                       r_idle <= r_idle + IDLE_W'(1);
    end

    assign w_idle_to = (r_state == ST_PLAY) && (r_idle == IDLE_W'(TIMEOUT_CYCLES));
`else
    assign w_idle_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_dead1     = is_dead(r_h1, r_prev1);
        w_dead2     = is_dead(r_h2, r_prev2);
        w_dec       = WIN_NONE;
        if (w_dead1 && w_dead2)  w_dec = WIN_DRAW;
        else if (w_dead1)        w_dec = WIN_P2;
        else if (w_dead2)        w_dec = WIN_P1;
        else if (r_turn == TURN_MAX)
            w_dec = (r_h1 > r_h2) ? WIN_P1 : (r_h2 > r_h1) ? WIN_P2 : WIN_DRAW;
        case (r_state)
            // The level also catches a pulse that began while judging.
            ST_PLAY:  if (w_rise || io_bus.actionEnable) w_state_nxt = ST_TURN;
                      else if (w_idle_to)                w_state_nxt = ST_OVER;
            ST_TURN:  if (w_fall) w_state_nxt = ST_JUDGE;
            ST_JUDGE: w_state_nxt = (w_dec == WIN_NONE) ? ST_PLAY : ST_OVER;
            ST_OVER:  w_state_nxt = ST_OVER;
            default:  w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_PLAY;
            r_turn  <= '0;
            r_h1    <= HEALTH_FULL;
            r_h2    <= HEALTH_FULL;
            r_prev1 <= HEALTH_FULL;
            r_prev2 <= HEALTH_FULL;
            r_over  <= 1'b0;
            r_win   <= WIN_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_TURN && w_fall) begin
                r_h1 <= io_bus.health1;
                r_h2 <= io_bus.health2;
                if (r_turn != TURN_MAX) r_turn <= r_turn + TURN_W'(1);
            end
            if (r_state == ST_JUDGE) begin
                if (w_dec == WIN_NONE) begin
                    r_prev1 <= r_h1;
                    r_prev2 <= r_h2;
                end else begin
                    r_over <= 1'b1;
                    r_win  <= w_dec;
                end
            end
            if (r_state == ST_PLAY && !io_bus.actionEnable && w_idle_to) begin
                r_over <= 1'b1;
                r_win  <= WIN_DRAW;
            end
        end
    end

    assign io_bus.isGameOver = r_over;
    assign io_bus.winner     = r_win;
    assign io_bus.turnCount  = r_turn;
endmodule

// File: tb/tb_game_referee.sv
// Drives two referees (turn limits 32 and 4) with one stimulus and checks both against a turn-level model.
module tb_game_referee;
    import game_referee_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ae;
    logic [1:0] hp1, hp2;

    always #5 clk = ~clk;

    game_referee_if #(.TURN_W(6)) bus_a ();
    game_referee_if #(.TURN_W(6)) bus_b ();

    assign bus_a.actionEnable = ae;
    assign bus_a.health1      = hp1;
    assign bus_a.health2      = hp2;
    assign bus_b.actionEnable = ae;
    assign bus_b.health1      = hp1;
    assign bus_b.health2      = hp2;

    game_referee #(.MAX_TURNS(32), .TURN_W(6), .TIMEOUT_CYCLES(20)) dut_a (
        .clk(clk), .reset(reset), .io_bus(bus_a));
    game_referee #(.MAX_TURNS(4), .TURN_W(6), .TIMEOUT_CYCLES(20)) dut_b (
        .clk(clk), .reset(reset), .io_bus(bus_b));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Game model: one step per completed turn, straight from the referee's rules.
    int m_turn[2], m_p1[2], m_p2[2], m_over[2], m_win[2];
    int m_max[2] = '{32, 4};

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_turn[k] = 0; m_p1[k] = 3; m_p2[k] = 3; m_over[k] = 0; m_win[k] = 0;
        end
    endfunction

    function automatic void m_step(input int h1, input int h2);
        bit d1, d2;
        for (int k = 0; k < 2; k++) begin
            if (m_over[k] != 0) continue;
            if (m_turn[k] < m_max[k]) m_turn[k]++;
            d1 = (h1 == 0) || (h1 > m_p1[k] + 1);
            d2 = (h2 == 0) || (h2 > m_p2[k] + 1);
            if (d1 && d2)               m_win[k] = 3;
            else if (d1)                m_win[k] = 2;
            else if (d2)                m_win[k] = 1;
            else if (m_turn[k] == m_max[k])
                m_win[k] = (h1 > h2) ? 1 : (h2 > h1) ? 2 : 3;
            else begin
                m_p1[k] = h1; m_p2[k] = h2;
            end
            if (m_win[k] != 0) m_over[k] = 1;
        end
    endfunction

    task automatic check_all(input string tag);
        chk($sformatf("%s.a.over", tag), 32'(bus_a.isGameOver), m_over[0]);
        chk($sformatf("%s.a.win",  tag), 32'(bus_a.winner),     m_win[0]);
        chk($sformatf("%s.a.turn", tag), 32'(bus_a.turnCount),  m_turn[0]);
        chk($sformatf("%s.b.over", tag), 32'(bus_b.isGameOver), m_over[1]);
        chk($sformatf("%s.b.win",  tag), 32'(bus_b.winner),     m_win[1]);
        chk($sformatf("%s.b.turn", tag), 32'(bus_b.turnCount),  m_turn[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ae    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    // Health is random except on the cycle feeding the falling-edge sample.
    task automatic turn(input int h1, input int h2, input int len, input string tag);
        @(negedge clk);
        ae = 1'b1; hp1 = 2'($urandom_range(0, 3)); hp2 = 2'($urandom_range(0, 3));
        repeat (len - 1) begin
            @(negedge clk);
            hp1 = 2'($urandom_range(0, 3)); hp2 = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        ae = 1'b0; hp1 = 2'(h1); hp2 = 2'(h2);
        @(negedge clk);
        hp1 = 2'($urandom_range(0, 3)); hp2 = 2'($urandom_range(0, 3));
        @(negedge clk);
        m_step(h1, h2);
        check_all(tag);
        @(negedge clk);
    endtask

    int h1r, h2r;

    initial begin
        reset = 1'b1; ae = 1'b0; hp1 = 2'd3; hp2 = 2'd3;
        m_reset();
        #1;
        chk("rst.over", 32'(bus_a.isGameOver), 0);
        chk("rst.win",  32'(bus_a.winner), 0);
        chk("rst.turn", 32'(bus_a.turnCount), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) turn(3, 3, $urandom_range(1, 3), "full");
        chk("five.turn", 32'(bus_a.turnCount), 5);
        chk("five.over", 32'(bus_a.isGameOver), 0);
        chk("limit4.draw", 32'(bus_b.winner), 3);

        do_reset();
        turn(3, 0, 2, "ko");
        chk("ko.win", 32'(bus_a.winner), 1);
        turn(3, 3, 1, "ko_after1");
        turn(2, 2, 3, "ko_after2");
        chk("ko.frozen", 32'(bus_a.turnCount), 1);

        do_reset();
        turn(1, 3, 1, "wrap1");
        turn(3, 3, 2, "wrap2");
        chk("wrap.win", 32'(bus_a.winner), 2);

        do_reset();
        turn(0, 0, 1, "both");
        chk("both.win", 32'(bus_a.winner), 3);

        do_reset();
        for (int i = 0; i < 3; i++) turn(3, 3, 1, "lim");
        turn(2, 1, 2, "lim_p1");
        chk("lim.p1", 32'(bus_b.winner), 1);
        do_reset();
        for (int i = 0; i < 3; i++) turn(3, 3, 2, "lim");
        turn(2, 2, 1, "lim_eq");
        chk("lim.eq", 32'(bus_b.winner), 3);

        do_reset();
        turn(3, 3, 1, "mid1");
        turn(3, 3, 1, "mid2");
        @(negedge clk); ae = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid.turn", 32'(bus_a.turnCount), 0);
        chk("mid.over", 32'(bus_a.isGameOver), 0);
        chk("mid.win",  32'(bus_a.winner), 0);
        ae = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
        turn(3, 3, 2, "mid_after");
        chk("mid.recount", 32'(bus_a.turnCount), 1);

        for (int g = 0; g < 25; g++) begin
            do_reset();
            for (int t = 0; t < 40 && !(m_over[0] != 0 && m_over[1] != 0); t++) begin
                h1r = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3);
                h2r = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 3);
                turn(h1r, h2r, $urandom_range(1, 4), $sformatf("rnd%0d_%0d", g, t));
            end
        end

`ifdef REFEREE_INACTIVITY_TIMEOUT_EN
        do_reset();
        repeat (12) @(negedge clk);
        chk("idle.early", 32'(bus_a.isGameOver), 0);
        repeat (12) @(negedge clk);
        chk("idle.over", 32'(bus_a.isGameOver), 1);
        chk("idle.win",  32'(bus_a.winner), 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
